// File: rtl/morse_pkg.sv
// Shared state encoding and default timing constants for the Morse letter sequencer.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MARK = 2'b01,
        ST_GAP  = 2'b10,
        ST_LGAP = 2'b11
    } morse_state_e;

    localparam int DEF_MAX_LEN    = 4;
    localparam int DEF_TICK_DIV   = 25_000_000;
    localparam int DEF_DASH_UNITS = 3;
    localparam int DEF_GAP_UNITS  = 1;
    localparam int DEF_LGAP_UNITS = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/morse_sequencer_if.sv
// Letter request handshake plus lamp/status outputs of the Morse sequencer.
interface morse_sequencer_if
    import morse_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN
) ();
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               start_i;
    logic [MAX_LEN-1:0] code_i;
    logic [LEN_W-1:0]   size_i;
    logic               ready_o;
    logic               busy_o;
    logic               dot_o;
    logic               dash_o;
    logic [1:0]         state_o;
    logic               done_o;

    modport master (
        output start_i, code_i, size_i,
        input  ready_o, busy_o, dot_o, dash_o, state_o, done_o
    );

    modport slave (
        input  start_i, code_i, size_i,
        output ready_o, busy_o, dot_o, dash_o, state_o, done_o
    );
endinterface

// File: rtl/morse_unit_timer.sv
// Restartable TICK_DIV prescaler feeding a unit counter; tc_o marks the last cycle of units_i units.
module morse_unit_timer
    import morse_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int CNT_W    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart_i,
    input  logic [CNT_W-1:0] units_i,
    output logic             tc_o
);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] unit_q, unit_d;
    logic             unit_end;

    always_comb begin
        unit_end = (div_q == DIV_LAST);
        tc_o     = unit_end && (unit_q == (units_i - CNT_W'(1)));
        div_d    = div_q;
        unit_d   = unit_q;
        if (restart_i) begin
            div_d  = '0;
            unit_d = '0;
        end else if (unit_end) begin
            div_d  = '0;
            unit_d = unit_q + CNT_W'(1);
        end else begin
            div_d  = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            unit_q <= '0;
        end else begin
            div_q  <= div_d;
            unit_q <= unit_d;
        end
    end
endmodule

// File: rtl/morse_sequencer.sv
// Morse letter sequencer: one active letter shifted out as dot/dash marks, plus a one-deep pending buffer.
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int DASH_UNITS = DEF_DASH_UNITS,
    parameter int GAP_UNITS  = DEF_GAP_UNITS,
    parameter int LGAP_UNITS = DEF_LGAP_UNITS
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    morse_sequencer_if.slave  bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int CNT_W = $clog2(max3(DASH_UNITS, GAP_UNITS, LGAP_UNITS) + 1);

    morse_state_e       state_q, state_d;
    logic [MAX_LEN-1:0] shift_q, shift_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [MAX_LEN-1:0] pend_code_q, pend_code_d;
    logic [LEN_W-1:0]   pend_size_q, pend_size_d;
    logic               pend_vld_q, pend_vld_d;
    logic               pend_clr_q, pend_clr_d;
    logic               zdone_q, zdone_d;

    logic               accept;
    logic [LEN_W-1:0]   acc_size;
    logic [CNT_W-1:0]   units;
    logic               tc;
    logic               restart;

    function automatic logic [LEN_W-1:0] clamp_size(input logic [LEN_W-1:0] s);
        return (s > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : s;
    endfunction

    // Every tc ends its state, so restarting on tc (and holding in IDLE) restarts on each entry.
    assign restart = (state_q == ST_IDLE) || tc;

    morse_unit_timer #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk       (CLOCK_50),
        .rst_n     (rst),
        .restart_i (restart),
        .units_i   (units),
        .tc_o      (tc)
    );

    always_comb begin
        accept      = bus.start_i && !pend_vld_q;
        acc_size    = clamp_size(bus.size_i);
        state_d     = state_q;
        shift_d     = shift_q;
        rem_d       = rem_q;
        pend_code_d = pend_code_q;
        pend_size_d = pend_size_q;
        pend_vld_d  = pend_vld_q;
        pend_clr_d  = 1'b0;
        zdone_d     = 1'b0;
        units       = CNT_W'(1);

        // The slot is released one edge after the hand-off so it never refills on the same edge.
        if (pend_clr_q) pend_vld_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (acc_size == '0) begin
                        zdone_d = 1'b1;
                    end else begin
                        state_d = ST_MARK;
                        shift_d = bus.code_i;
                        rem_d   = acc_size;
                    end
                end
            end
            ST_MARK: begin
                units = shift_q[0] ? CNT_W'(DASH_UNITS) : CNT_W'(1);
                if (tc) begin
                    if (rem_q > LEN_W'(1)) begin
                        shift_d = shift_q >> 1;
                        rem_d   = rem_q - LEN_W'(1);
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_LGAP;
                    end
                end
            end
            ST_GAP: begin
                units = CNT_W'(GAP_UNITS);
                if (tc) state_d = ST_MARK;
            end
            ST_LGAP: begin
                units = CNT_W'(LGAP_UNITS);
                if (tc) begin
                    if (pend_vld_q) begin
                        pend_clr_d = 1'b1;
                        if (pend_size_q == '0) begin
                            state_d = ST_IDLE;
                            zdone_d = 1'b1;
                        end else begin
                            state_d = ST_MARK;
                            shift_d = pend_code_q;
                            rem_d   = pend_size_q;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase

        if (accept && (state_q != ST_IDLE)) begin
            pend_code_d = bus.code_i;
            pend_size_d = acc_size;
            pend_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            rem_q       <= '0;
            pend_code_q <= '0;
            pend_size_q <= '0;
            pend_vld_q  <= 1'b0;
            pend_clr_q  <= 1'b0;
            zdone_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            rem_q       <= rem_d;
            pend_code_q <= pend_code_d;
            pend_size_q <= pend_size_d;
            pend_vld_q  <= pend_vld_d;
            pend_clr_q  <= pend_clr_d;
            zdone_q     <= zdone_d;
        end
    end

    assign bus.state_o = state_q;
    assign bus.busy_o  = (state_q != ST_IDLE);
    assign bus.ready_o = !pend_vld_q;
    assign bus.dot_o   = (state_q == ST_MARK) && !shift_q[0];
    assign bus.dash_o  = (state_q == ST_MARK) && shift_q[0];
    assign bus.done_o  = ((state_q == ST_LGAP) && tc) || zdone_q;
endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer: TICK_DIV=1 instance for sequencing, TICK_DIV=3 instance for timing.
module tb_morse_sequencer;
    import morse_pkg::*;

    logic CLOCK_50 = 1'b0;
    logic rst      = 1'b0;
    int   n_cmp    = 0;
    int   n_bad    = 0;

    morse_sequencer_if #(.MAX_LEN(4)) bus1 ();
    morse_sequencer_if #(.MAX_LEN(4)) bus3 ();

    morse_sequencer #(
        .MAX_LEN(4), .TICK_DIV(1), .DASH_UNITS(3), .GAP_UNITS(1), .LGAP_UNITS(3)
    ) dut1 (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .bus      (bus1)
    );

    morse_sequencer #(
        .MAX_LEN(4), .TICK_DIV(3), .DASH_UNITS(3), .GAP_UNITS(1), .LGAP_UNITS(3)
    ) dut3 (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .bus      (bus3)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // {state[1:0], dot, dash, done}
    function automatic logic [4:0] obs1();
        return {bus1.state_o, bus1.dot_o, bus1.dash_o, bus1.done_o};
    endfunction

    function automatic logic [4:0] obs3();
        return {bus3.state_o, bus3.dot_o, bus3.dash_o, bus3.done_o};
    endfunction

    task automatic send1(input logic [3:0] code, input logic [2:0] size);
        bus1.start_i = 1'b1;
        bus1.code_i  = code;
        bus1.size_i  = size;
        tick();
        bus1.start_i = 1'b0;
    endtask

    logic [4:0] exp_a [1:9] = '{5'b01100, 5'b10000, 5'b01010, 5'b01010, 5'b01010,
                                5'b11000, 5'b11000, 5'b11001, 5'b00000};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int dash_cyc, dash_rise, dot_cyc, done_cnt, lgap_cyc;
        logic prev;

        bus1.start_i = 1'b0; bus1.code_i = '0; bus1.size_i = '0;
        bus3.start_i = 1'b0; bus3.code_i = '0; bus3.size_i = '0;

        // Reset held, then released with no request
        repeat (2) tick();
        check_eq("rst_obs1", obs1(), 5'b00000);
        check_eq("rst_ready1", bus1.ready_o, 1);
        check_eq("rst_busy1", bus1.busy_o, 0);
        check_eq("rst_obs3", obs3(), 5'b00000);
        rst = 1'b1;
        repeat (3) tick();
        check_eq("idle_obs1", obs1(), 5'b00000);
        check_eq("idle_ready1", bus1.ready_o, 1);
        check_eq("idle_busy1", bus1.busy_o, 0);

        // Letter A: dot, gap, dash, letter gap
        send1(4'b0010, 3'd2);
        for (int c = 1; c <= 9; c++) begin
            check_eq($sformatf("A_c%0d", c), obs1(), exp_a[c]);
            if (c == 1) check_eq("A_busy_c1", bus1.busy_o, 1);
            if (c < 9) tick();
        end
        check_eq("A_ready_end", bus1.ready_o, 1);

        // Back-to-back: A then a single dot queued during the gap
        send1(4'b0010, 3'd2);
        tick();
        check_eq("b2b_ready_c2", bus1.ready_o, 1);
        bus1.start_i = 1'b1; bus1.code_i = 4'b0000; bus1.size_i = 3'd1;
        tick();
        bus1.start_i = 1'b0;
        check_eq("b2b_ready_c3", bus1.ready_o, 0);
        repeat (5) tick();
        check_eq("b2b_c8", obs1(), 5'b11001);
        tick();
        check_eq("b2b_c9", obs1(), 5'b01100);
        check_eq("b2b_ready_c9", bus1.ready_o, 0);
        tick();
        check_eq("b2b_c10", obs1(), 5'b11000);
        check_eq("b2b_ready_c10", bus1.ready_o, 1);
        repeat (2) tick();
        check_eq("b2b_c12", obs1(), 5'b11001);
        tick();
        check_eq("b2b_c13", obs1(), 5'b00000);

        // Size 0: done pulse only
        send1(4'b0000, 3'd0);
        check_eq("z_c1", obs1(), 5'b00001);
        check_eq("z_ready_c1", bus1.ready_o, 1);
        tick();
        check_eq("z_c2", obs1(), 5'b00000);

        // Size 6 clamps to 4 dashes
        send1(4'b1111, 3'd6);
        dash_cyc = 0; dash_rise = 0; dot_cyc = 0; done_cnt = 0; prev = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (bus1.dash_o) dash_cyc++;
            if (bus1.dash_o && !prev) dash_rise++;
            if (bus1.dot_o) dot_cyc++;
            if (bus1.done_o) done_cnt++;
            prev = bus1.dash_o;
            tick();
        end
        check_eq("clamp_dash_cycles", dash_cyc, 12);
        check_eq("clamp_dash_count", dash_rise, 4);
        check_eq("clamp_dot_cycles", dot_cyc, 0);
        check_eq("clamp_done_count", done_cnt, 1);
        check_eq("clamp_end_state", bus1.state_o, 0);

        // Reset in the middle of a dash with a letter pending
        send1(4'b0001, 3'd1);
        bus1.start_i = 1'b1; bus1.code_i = 4'b0010; bus1.size_i = 3'd2;
        tick();
        bus1.start_i = 1'b0;
        check_eq("mid_dash_on", bus1.dash_o, 1);
        check_eq("mid_ready_pend", bus1.ready_o, 0);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_dash", bus1.dash_o, 0);
        check_eq("mid_rst_obs", obs1(), 5'b00000);
        check_eq("mid_rst_ready", bus1.ready_o, 1);
        check_eq("mid_rst_busy", bus1.busy_o, 0);
        tick();
        rst = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check_eq($sformatf("post_rst_obs_c%0d", c), obs1(), 5'b00000);
            check_eq($sformatf("post_rst_ready_c%0d", c), bus1.ready_o, 1);
        end

        // TICK_DIV=3 single dot
        bus3.start_i = 1'b1; bus3.code_i = 4'b0000; bus3.size_i = 3'd1;
        tick();
        bus3.start_i = 1'b0;
        check_eq("td3_c1", obs3(), 5'b01100);
        dot_cyc = 0; lgap_cyc = 0; done_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            if (bus3.dot_o) dot_cyc++;
            if (bus3.state_o == 2'b11) lgap_cyc++;
            if (bus3.done_o) done_cnt++;
            if (c == 12) check_eq("td3_done_c12", bus3.done_o, 1);
            if (c == 13) check_eq("td3_c13", obs3(), 5'b00000);
            tick();
        end
        check_eq("td3_dot_cycles", dot_cyc, 3);
        check_eq("td3_lgap_cycles", lgap_cyc, 9);
        check_eq("td3_done_count", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/morse_sequencer.md
MORSE_SEQUENCER -- requirements
Module: morse_sequencer

Interface
REQ-001 Parameter MAX_LEN, default 4: maximum elements per letter.
REQ-002 Parameter TICK_DIV, default 25_000_000: CLOCK_50 cycles per time unit (0.5 s); legal range >= 1.
REQ-003 Parameter DASH_UNITS, default 3: dash length in units.
REQ-004 Parameter GAP_UNITS, default 1: intra-letter gap in units.
REQ-005 Parameter LGAP_UNITS, default 3: inter-letter gap in units.
REQ-006 CLOCK_50  input  1  sole clock, rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 start_i  input  1  letter request, accepted on an edge where start_i && ready_o.
REQ-009 code_i  input  MAX_LEN  element bits, bit0 sent first; 0=dot, 1=dash.
REQ-010 size_i  input  LEN_W=$clog2(MAX_LEN+1)  element count.
REQ-011 ready_o  output  1  request slot free.
REQ-012 busy_o  output  1  high in any state other than IDLE.
REQ-013 dot_o  output  1  dot lamp.
REQ-014 dash_o  output  1  dash lamp.
REQ-015 state_o  output  2  IDLE=00, MARK=01, GAP=10, LGAP=11.
REQ-016 done_o  output  1  one-cycle pulse in the final cycle of a letter.

Function
REQ-017 The block SHALL hold one active letter (shift register, remaining count) and one pending buffer (code, size, valid).
REQ-018 ready_o SHALL equal !pending_valid; it is 1 in IDLE.
REQ-019 An acceptance in IDLE SHALL load the active letter directly; an acceptance in any other state SHALL fill the pending buffer.
REQ-020 size_i > MAX_LEN SHALL be clamped to MAX_LEN at acceptance.
REQ-021 An acceptance in IDLE with size 0 SHALL stay in IDLE and pulse done_o in the following cycle with no marks.
REQ-022 An acceptance in IDLE with size >= 1 SHALL enter MARK on the accepting edge; the first mark appears in the next cycle (latency 1).
REQ-023 MARK SHALL last 1 unit (current bit 0, dot_o=1) or DASH_UNITS units (bit 1, dash_o=1); dot_o and dash_o are never high together and are 0 outside MARK.
REQ-024 At the end of MARK: if elements remain, the block SHALL shift the code and enter GAP; otherwise it enters LGAP.
REQ-025 GAP SHALL last GAP_UNITS units, then return to MARK.
REQ-026 LGAP SHALL last LGAP_UNITS units; done_o SHALL be high in its last cycle.
REQ-027 At the end of LGAP: if the pending buffer is valid, it SHALL move to active (size 0 treated as 1 dot is forbidden; size 0 goes to IDLE with done_o the next cycle) and MARK SHALL be entered; otherwise the block enters IDLE.
REQ-028 The pending slot freed at the end of LGAP SHALL become ready in the next cycle; no same-edge refill.
REQ-029 The unit timer SHALL restart at every state entry so each state lasts exactly N*TICK_DIV cycles.
REQ-030 Unit counter width SHALL be $clog2(TICK_DIV) (minimum 1); unit count width SHALL be $clog2(max(DASH_UNITS,GAP_UNITS,LGAP_UNITS)+1).

Reset
REQ-031 While rst=0, outputs SHALL be: state_o=00, dot_o=0, dash_o=0, done_o=0, busy_o=0, ready_o=1, asynchronously, including mid-letter.
REQ-032 Reset SHALL clear the pending buffer, shift register and both counters; the first acceptance occurs on the first edge after rst rises.

Structure
REQ-033 Package morse_pkg SHALL hold the state enum typedef (2-bit encoding per REQ-015) and the default timing constants.
REQ-034 Sub-module morse_unit_timer SHALL provide a restartable TICK_DIV divider and unit counter with a terminal-count output; the FSM, shift register and pending buffer reside in morse_sequencer.

Verification (TICK_DIV=1, DASH=3, GAP=1, LGAP=3, MAX_LEN=4 unless stated)
REQ-035 Reset: rst low -> all outputs 0, ready_o=1, state_o=00; release -> unchanged until start_i.
REQ-036 Letter A: code_i=4'b0010, size_i=2, accepted at cycle 0 -> dot_o at cycle 1; gap at cycle 2; dash_o at cycles 3-5; LGAP at cycles 6-8; done_o at cycle 8; IDLE at cycle 9.
REQ-037 Back-to-back: second letter (code 0, size 1) sent at cycle 2 -> ready_o=0 from cycle 3; dot_o at cycle 9 with no IDLE cycle; ready_o=1 at cycle 10.
REQ-038 Edges: size_i=0 -> done_o at cycle 1 with no marks; size_i=6 with code 4'b1111 -> exactly 4 dashes.
REQ-039 rst low during a dash -> dash_o=0 within the same cycle (async); after release, pending is empty and state is IDLE.
REQ-040 TICK_DIV=3, single dot -> dot_o high for exactly 3 cycles; LGAP lasts 9 cycles.
